// File: rtl/plot_arbiter.sv
// plot_arbiter: shares the VGA adapter's single pixel-write port between two
// box-drawing requesters. Requests are granted round-robin, then the latched
// rectangle is walked row-major, one pixel per clock.
//
// Optional build macro: PLOT_ARBITER_CLIP_EN
//   defined   - pixels outside SCREEN_W x SCREEN_H are suppressed (plot=0) but
//               still take their cycle, so box timing does not change.
//   undefined - no screen compare is built; coordinates wrap at 256/128.
//
// state | meaning
// IDLE  | waiting for a request; the winner's box is latched on leaving
// LOAD  | one cycle; grant pulse to the winner
// DRAW  | one pixel per cycle, row-major over (w+1) x (h+1)
// DONE  | one cycle; done pulse, priority passes to the other requester
module plot_arbiter #(
  parameter int SZ_BITS  = 4,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [7:0]         x0,
  input  logic [6:0]         y0,
  input  logic [SZ_BITS-1:0] w0,
  input  logic [SZ_BITS-1:0] h0,
  input  logic [2:0]         c0,
  input  logic [7:0]         x1,
  input  logic [6:0]         y1,
  input  logic [SZ_BITS-1:0] w1,
  input  logic [SZ_BITS-1:0] h1,
  input  logic [2:0]         c1,
  output logic [1:0]         grant,
  output logic [1:0]         done,
  output logic               busy,
  output logic [7:0]         outx,
  output logic [6:0]         outy,
  output logic [2:0]         outcolor,
  output logic               plot
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic               ptr_q;   // requester favoured when both ask
  logic               win_q;   // requester owning the current box
  logic               win_d;

  logic [7:0]         ox_q;
  logic [6:0]         oy_q;
  logic [SZ_BITS-1:0] w_q;
  logic [SZ_BITS-1:0] h_q;
  logic [2:0]         c_q;

  // cx/cy index the pixel currently on the output registers
  logic [SZ_BITS-1:0] cx_q;
  logic [SZ_BITS-1:0] cy_q;

  logic [7:0]         outx_q;
  logic [6:0]         outy_q;
  logic [2:0]         outcolor_q;
  logic               plot_q;

  logic               last_pix;
  logic               pix_next;
  logic [SZ_BITS-1:0] nx_cx;
  logic [SZ_BITS-1:0] nx_cy;
  logic [7:0]         pix_x;
  logic [6:0]         pix_y;
  logic               pix_vis;

  assign last_pix = (cx_q == w_q) && (cy_q == h_q);

  // Next-state decode and round-robin winner selection
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    case (state_q)
      S_IDLE: begin
        if (req != 2'b00) begin
          state_d = S_LOAD;
          case (req)
            2'b01:   win_d = 1'b0;
            2'b10:   win_d = 1'b1;
            default: win_d = ptr_q;
          endcase
        end
      end
      S_LOAD:  state_d = S_DRAW;
      S_DRAW:  if (last_pix) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Index of the pixel to present next cycle; LOAD presents the origin
  always_comb begin
    nx_cx    = '0;
    nx_cy    = '0;
    pix_next = 1'b0;
    if (state_q == S_LOAD) begin
      pix_next = 1'b1;
    end else if ((state_q == S_DRAW) && !last_pix) begin
      pix_next = 1'b1;
      if (cx_q == w_q) begin
        nx_cx = '0;
        nx_cy = cy_q + 1'b1;
      end else begin
        nx_cx = cx_q + 1'b1;
        nx_cy = cy_q;
      end
    end
  end

`ifdef PLOT_ARBITER_CLIP_EN
  localparam logic [8:0] SCR_W = 9'(SCREEN_W);
  localparam logic [7:0] SCR_H = 8'(SCREEN_H);

  logic [8:0] sum_x;
  logic [7:0] sum_y;

  // Full-width sums so the screen compare sees the true coordinate
  always_comb begin
    sum_x   = {1'b0, ox_q} + 9'(nx_cx);
    sum_y   = {1'b0, oy_q} + 8'(nx_cy);
    pix_x   = sum_x[7:0];
    pix_y   = sum_y[6:0];
    pix_vis = (sum_x < SCR_W) && (sum_y < SCR_H);
  end
`else
  // Without clipping the coordinate simply wraps on the screen bus width
  always_comb begin
    pix_x   = ox_q + 8'(nx_cx);
    pix_y   = oy_q + 7'(nx_cy);
    pix_vis = 1'b1;
  end
`endif

  // State, box latch, scan counters and registered pixel port
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= 1'b0;
      win_q      <= 1'b0;
      ox_q       <= '0;
      oy_q       <= '0;
      w_q        <= '0;
      h_q        <= '0;
      c_q        <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      outx_q     <= '0;
      outy_q     <= '0;
      outcolor_q <= '0;
      plot_q     <= 1'b0;
    end else begin
      state_q <= state_d;

      if ((state_q == S_IDLE) && (state_d == S_LOAD)) begin
        win_q <= win_d;
        cx_q  <= '0;
        cy_q  <= '0;
        if (win_d) begin
          ox_q <= x1;
          oy_q <= y1;
          w_q  <= w1;
          h_q  <= h1;
          c_q  <= c1;
        end else begin
          ox_q <= x0;
          oy_q <= y0;
          w_q  <= w0;
          h_q  <= h0;
          c_q  <= c0;
        end
      end

      if (pix_next) begin
        cx_q <= nx_cx;
        cy_q <= nx_cy;
      end

      // Clipped pixels leave the port holding the last visible pixel
      plot_q <= pix_next && pix_vis;
      if (pix_next && pix_vis) begin
        outx_q     <= pix_x;
        outy_q     <= pix_y;
        outcolor_q <= c_q;
      end

      if (state_q == S_DONE) begin
        ptr_q <= ~win_q;
      end
    end
  end

  assign grant    = (state_q == S_LOAD) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign done     = (state_q == S_DONE) ? (win_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy     = (state_q != S_IDLE);
  assign outx     = outx_q;
  assign outy     = outy_q;
  assign outcolor = outcolor_q;
  assign plot     = plot_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// Testbench for plot_arbiter: directed scenarios plus two randomized
// requesters, checked every cycle against a transaction-level schedule model.
module tb_plot_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ra = 1'b0, rb = 1'b0;
  logic [1:0]  req;
  logic [7:0]  x0 = '0, x1 = '0;
  logic [6:0]  y0 = '0, y1 = '0;
  logic [3:0]  w0 = '0, h0 = '0, w1 = '0, h1 = '0;
  logic [2:0]  c0 = '0, c1 = '0;
  logic [1:0]  grant, done;
  logic        busy, plot;
  logic [7:0]  outx;
  logic [6:0]  outy;
  logic [2:0]  outcolor;

  assign req = {rb, ra};

  plot_arbiter #(.SZ_BITS(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .reset(reset), .req(req),
    .x0(x0), .y0(y0), .w0(w0), .h0(h0), .c0(c0),
    .x1(x1), .y1(y1), .w1(w1), .h1(h1), .c1(c1),
    .grant(grant), .done(done), .busy(busy),
    .outx(outx), .outy(outy), .outcolor(outcolor), .plot(plot)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model: per-cycle expected schedule ----------
  typedef struct {
    logic [1:0] g;
    logic [1:0] d;
    logic       b;
    logic       pix;
    logic       vis;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } rec_t;

  rec_t       sched[$];
  int         m_ptr = 0;
  logic [7:0] lx = '0;
  logic [6:0] ly = '0;
  logic [2:0] lc = '0;
  logic       rst_seen = 1'b1;
  rec_t       e;
  logic       was_idle;
  int         who;

  always @(posedge clock) rst_seen <= reset;

  task automatic plan_box(input int wn, input int bx, input int by,
                          input int bw, input int bh, input int bc);
    rec_t r;
    r = '{g: 2'(1 << wn), d: 2'b00, b: 1'b1, pix: 1'b0, vis: 1'b0, x: '0, y: '0, c: '0};
    sched.push_back(r);
    for (int row = 0; row <= bh; row++) begin
      for (int col = 0; col <= bw; col++) begin
        int xs, ys;
        xs = bx + col;
        ys = by + row;
        r.g   = 2'b00;
        r.pix = 1'b1;
`ifdef PLOT_ARBITER_CLIP_EN
        r.vis = (xs < 160) && (ys < 120);
`else
        r.vis = 1'b1;
`endif
        r.x = 8'(xs % 256);
        r.y = 7'(ys % 128);
        r.c = 3'(bc);
        sched.push_back(r);
      end
    end
    r = '{g: 2'b00, d: 2'(1 << wn), b: 1'b1, pix: 1'b0, vis: 1'b0, x: '0, y: '0, c: '0};
    sched.push_back(r);
    m_ptr = 1 - wn;
  endtask

  // Compare every cycle; arbitrate in modelled idle cycles
  always @(negedge clock) begin
    if (rst_seen) begin
      sched.delete();
      m_ptr = 0;
      lx = '0; ly = '0; lc = '0;
    end
    if (sched.size() == 0) begin
      e = '{g: 2'b00, d: 2'b00, b: 1'b0, pix: 1'b0, vis: 1'b0, x: '0, y: '0, c: '0};
      was_idle = 1'b1;
    end else begin
      e = sched.pop_front();
      was_idle = 1'b0;
    end
    check("grant", 32'(grant), 32'(e.g));
    check("done", 32'(done), 32'(e.d));
    check("busy", 32'(busy), 32'(e.b));
    check("plot", 32'(plot), 32'(e.pix && e.vis));
    if (e.pix && e.vis) begin
      check("outx", 32'(outx), 32'(e.x));
      check("outy", 32'(outy), 32'(e.y));
      check("outcolor", 32'(outcolor), 32'(e.c));
      lx = e.x; ly = e.y; lc = e.c;
    end else begin
      check("hold_x", 32'(outx), 32'(lx));
      check("hold_y", 32'(outy), 32'(ly));
      check("hold_c", 32'(outcolor), 32'(lc));
    end
    if (was_idle && !reset && (req != 2'b00)) begin
      if (req == 2'b01)      who = 0;
      else if (req == 2'b10) who = 1;
      else                   who = m_ptr;
      if (who == 0) plan_box(0, x0, y0, w0, h0, c0);
      else          plan_box(1, x1, y1, w1, h1, c1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int wn, input int bx, input int by,
                         input int bw, input int bh, input int bc);
    if (wn == 0) begin
      x0 = 8'(bx); y0 = 7'(by); w0 = 4'(bw); h0 = 4'(bh); c0 = 3'(bc); ra = 1'b1;
    end else begin
      x1 = 8'(bx); y1 = 7'(by); w1 = 4'(bw); h1 = 4'(bh); c1 = 3'(bc); rb = 1'b1;
    end
  endtask

  // Waits for this requester's grant, then drops its request; n = cycles taken
  task automatic wait_grant(input int wn, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!grant[wn] && n < 3000);
    if (!grant[wn]) check("grant_timeout", 32'(grant[wn]), 32'd1);
    if (wn == 0) ra = 1'b0; else rb = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rand_requester(input int wn, input int nbox);
    int n;
    for (int k = 0; k < nbox; k++) begin
      repeat ($urandom_range(0, 12)) tick();
      set_req(wn, $urandom_range(0, 255), $urandom_range(0, 127),
              $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 7));
      wait_grant(wn, n);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n, np, nc;
    logic [1:0] rr_exp [3];
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01;

    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_outx", 32'(outx), 32'd0);
    tick();

    // single-pixel box from requester 0
    set_req(0, 10, 20, 0, 0, 3'b100);
    wait_grant(0, n);
    check("lat_grant", 32'(n), 32'd1);
    tick();
    check("lat_plot", 32'(plot), 32'd1);
    wait_idle();
    repeat (2) tick();

    // 3x2 box from requester 1
    set_req(1, 5, 7, 2, 1, 3'b011);
    wait_grant(1, n);
    wait_idle();
    repeat (2) tick();

    // both requesting continuously after a reset
    pulse_reset();
    set_req(0, 30, 40, 1, 1, 1);
    set_req(1, 60, 70, 2, 0, 2);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin tick(); n++; end while (grant == 2'b00 && n < 200);
      check("rr_order", 32'(grant), 32'(rr_exp[k]));
    end
    ra = 1'b0; rb = 1'b0;
    wait_idle();
    repeat (2) tick();

    // reset during the third pixel of a 4x4 box
    set_req(0, 40, 30, 3, 3, 2);
    wait_grant(0, n);
    np = 0; n = 0;
    while (np < 3 && n < 50) begin
      tick(); n++;
      if (plot) np++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_plot", 32'(plot), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    repeat (3) tick();
    set_req(1, 100, 50, 1, 2, 5);
    wait_grant(1, n);
    wait_idle();
    repeat (2) tick();

    // box crossing the bottom-right screen corner
    set_req(0, 158, 118, 3, 3, 7);
    wait_grant(0, n);
    np = 0; nc = 0;
    do begin
      tick(); nc++;
      if (plot) np++;
    end while (done == 2'b00 && nc < 100);
    check("corner_draw_len", 32'(nc - 1), 32'd16);
`ifdef PLOT_ARBITER_CLIP_EN
    check("corner_plots", 32'(np), 32'd4);
`else
    check("corner_plots", 32'(np), 32'd16);
`endif
    wait_idle();
    repeat (2) tick();

    // requester 0 arrives while requester 1 is drawing
    set_req(1, 20, 20, 7, 3, 6);
    wait_grant(1, n);
    repeat (10) tick();
    set_req(0, 90, 90, 2, 2, 1);
    n = 0;
    do begin tick(); n++; end while (done != 2'b10 && n < 200);
    check("pend_done", 32'(done), 32'b10);
    n = 0;
    do begin tick(); n++; end while (grant != 2'b01 && n < 20);
    check("pend_gap", 32'(n), 32'd2);
    ra = 1'b0;
    wait_idle();
    repeat (2) tick();

    // randomized contention
    fork
      rand_requester(0, 15);
      rand_requester(1, 15);
    join
    wait_idle();
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
